// File: rtl/fht_loader_pkg.sv
// Shared types and helpers for the FHT bit-reverse frame loader.
// Contents:
//   state_t    - loader FSM states (IDLE, FILL, STREAM, FIN)
//   f_bit_rev  - reverses the low w bits of a row index
//   f_clog2    - ceil(log2(x)), used for the bank counter width
//   f_depth    - frame depth in rows for a given row-address width
package fht_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    // Reverse bit order of the low w bits of x; bits at and above w are returned as 0.
    function automatic logic [31:0] f_bit_rev(input logic [31:0] x, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                r[5'(i)] = x[5'(w - 1 - i)];
            end
        end
        return r;
    endfunction

    function automatic int unsigned f_clog2(input int unsigned x);
        return $clog2(x);
    endfunction

    function automatic int unsigned f_depth(input int unsigned a_bit);
        return 32'd1 << a_bit;
    endfunction

endpackage

// File: rtl/fht_bitrev_loader.sv
// Copies one FHT result frame from a BANKS-bank source RAM into the serial
// input of the next FHT/IFHT stage. Each source row is read once (linear or
// bit-reversed row order), buffered, and written out one bank per clock,
// gap-free across rows.
//
// Optional build macro: FHT_LOADER_SCALE_EN
//   defined   - output word is scaled by 1/N (N = BANKS * 2**A_BIT) with
//               round-half-up and positive saturation; one extra register
//               on the write side (writes and oDONE one cycle later).
//   undefined - output word is the source word sign-extended by EXT_BIT.
//
// Ports:
//   iCLK      clock
//   iRESET    synchronous reset, active low
//   iSTART    one-cycle start pulse (ignored while oBUSY)
//   iBITREV   row order select, captured with an accepted iSTART
//   oRD_ADDR  source row address shared by all banks
//   iRD_DATA  source row, bank k at [k*D_BIT +: D_BIT], RD_LAT clocks after oRD_ADDR
//   oWE       one-hot destination bank write enable
//   oWR_ADDR  destination row (linear)
//   oWR_DATA  destination word, D_BIT+EXT_BIT wide
//   oBUSY     transfer in progress (FILL, STREAM, FIN)
//   oDONE     one-cycle pulse after the last write
module fht_bitrev_loader
    import fht_loader_pkg::*;
#(
    parameter int unsigned D_BIT   = 18,
    parameter int unsigned EXT_BIT = 0,
    parameter int unsigned A_BIT   = 8,
    parameter int unsigned BANKS   = 4,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic                     iCLK,
    input  logic                     iRESET,
    input  logic                     iSTART,
    input  logic                     iBITREV,
    output logic [A_BIT-1:0]         oRD_ADDR,
    input  logic [BANKS*D_BIT-1:0]   iRD_DATA,
    output logic [BANKS-1:0]         oWE,
    output logic [A_BIT-1:0]         oWR_ADDR,
    output logic [D_BIT+EXT_BIT-1:0] oWR_DATA,
    output logic                     oBUSY,
    output logic                     oDONE
);

    localparam int unsigned DEPTH = f_depth(A_BIT);
    localparam int unsigned CB    = f_clog2(BANKS);
    localparam int unsigned OW    = D_BIT + EXT_BIT;

    localparam logic [CB-1:0]    PH_LAST  = CB'(BANKS - 1);
    localparam logic [CB-1:0]    PH_CAP   = CB'(RD_LAT);
    localparam logic [A_BIT-1:0] ROW_LAST = A_BIT'(DEPTH - 1);

    state_t             state;
    state_t             next_state;

    logic [CB-1:0]      ph;        // cycle phase within a row period, counted from the start edge
    logic [A_BIT-1:0]   rd_row;    // last destination row whose source read was issued
    logic               bitrev_q;
    logic [CB-1:0]      wr_bank;
    logic [A_BIT-1:0]   wr_row;
    logic [D_BIT-1:0]   row_buf [BANKS];

    logic               start_c;
    logic               issue_c;
    logic               capture_c;
    logic               write_c;
    logic               done_c;

    // First write-side register stage
    logic [BANKS-1:0]   we_q;
    logic [A_BIT-1:0]   addr_q;
    logic [OW-1:0]      word_q;
    logic               done_q;

    // Destination row j -> source row
    function automatic logic [A_BIT-1:0] f_row_map(input logic [A_BIT-1:0] j, input logic rev);
        return rev ? A_BIT'(f_bit_rev(32'(j), A_BIT)) : j;
    endfunction

    // State register
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and per-cycle control strobes.
    // Reads go out on the last phase of each row period so that the row
    // lands exactly when the previous row's last bank is being written;
    // the capture phase RD_LAT lines up with write bank BANKS-1.
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        issue_c    = 1'b0;
        capture_c  = 1'b0;
        write_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (iSTART) begin
                    start_c    = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                issue_c = (ph == PH_LAST) && (rd_row != ROW_LAST);
                if (ph == PH_CAP) begin
                    capture_c  = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                write_c   = 1'b1;
                issue_c   = (ph == PH_LAST) && (rd_row != ROW_LAST);
                capture_c = (ph == PH_CAP) && (wr_row != ROW_LAST);
                if ((wr_row == ROW_LAST) && (wr_bank == PH_LAST)) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counters, read address and first write stage
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            ph       <= '0;
            rd_row   <= '0;
            bitrev_q <= 1'b0;
            wr_bank  <= '0;
            wr_row   <= '0;
            oRD_ADDR <= '0;
            oBUSY    <= 1'b0;
            we_q     <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            oBUSY  <= (next_state != IDLE);
            ph     <= start_c ? '0 : ph + CB'(1);
            we_q   <= '0;
            done_q <= done_c;

            if (start_c) begin
                bitrev_q <= iBITREV;
                rd_row   <= '0;
                oRD_ADDR <= f_row_map('0, iBITREV);
                wr_bank  <= '0;
                wr_row   <= '0;
            end

            if (issue_c) begin
                rd_row   <= rd_row + A_BIT'(1);
                oRD_ADDR <= f_row_map(rd_row + A_BIT'(1), bitrev_q);
            end

            if (write_c) begin
                we_q    <= BANKS'(1) << wr_bank;
                addr_q  <= wr_row;
                word_q  <= OW'($signed(row_buf[wr_bank]));
                wr_bank <= wr_bank + CB'(1);
                // Row counter stops on the last row instead of wrapping
                if ((wr_bank == PH_LAST) && (wr_row != ROW_LAST)) begin
                    wr_row <= wr_row + A_BIT'(1);
                end
            end
        end
    end

    // Row buffer: the write stage reads the old row on the capture edge
    always_ff @(posedge iCLK) begin
        if (capture_c) begin
            for (int k = 0; k < int'(BANKS); k++) begin
                row_buf[k] <= iRD_DATA[k*D_BIT +: D_BIT];
            end
        end
    end

`ifdef FHT_LOADER_SCALE_EN
    localparam int unsigned S = A_BIT + CB;
    localparam logic [OW-1:0] RND     = OW'(64'd1 << (S - 1));
    localparam logic [OW-1:0] POS_MAX = {1'b0, {(OW-1){1'b1}}};

    // Round-half-up divide by 2**S; a positive input that overflows on the
    // rounding add is clamped to the largest positive value before the shift.
    function automatic logic [OW-1:0] f_scale(input logic [OW-1:0] x);
        logic [OW-1:0] sum;
        sum = x + RND;
        if (!x[OW-1] && sum[OW-1]) begin
            sum = POS_MAX;
        end
        return OW'($signed(sum) >>> S);
    endfunction

    // Scaling register stage
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            oWE      <= '0;
            oWR_ADDR <= '0;
            oWR_DATA <= '0;
            oDONE    <= 1'b0;
        end else begin
            oWE      <= we_q;
            oWR_ADDR <= addr_q;
            oWR_DATA <= f_scale(word_q);
            oDONE    <= done_q;
        end
    end
`else
    assign oWE      = we_q;
    assign oWR_ADDR = addr_q;
    assign oWR_DATA = word_q;
    assign oDONE    = done_q;
`endif

endmodule
